// File: rtl/audio_interpolator.sv
// Sample-rate smoother feeding the FM modulator: one-deep input buffer plus a
// linear ramp from the previous to the current sample over 2^S clocks.
module audio_interpolator #(
    parameter int A = 8,
    parameter int S = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [A-1:0] in_sample,
    output logic signed [A-1:0] audio,
    output logic                underrun
);

    localparam logic [1:0]   IDLE     = 2'd0;
    localparam logic [1:0]   RUN      = 2'd1;
    localparam logic [1:0]   HOLD     = 2'd2;
    localparam logic [S-1:0] CNT_LAST = {S{1'b1}};

    logic [1:0]          state;
    logic signed [A-1:0] prev;
    logic signed [A-1:0] cur;
    logic signed [A-1:0] pend;
    logic                pend_full;
    logic [S-1:0]        cnt;
    logic                take;

    logic signed [A+S:0] prev_ext;
    logic signed [A+S:0] diff_ext;
    logic signed [A+S:0] cnt_ext;
    logic signed [A+S:0] prod;
    logic signed [A+S:0] step;
    logic signed [A-1:0] interp;

    assign in_ready = enable && !pend_full;
    assign take     = in_valid && in_ready;

    // The shift is kept in its own signed variable so it stays arithmetic (floor);
    // the sum always lies between prev and cur, so truncation never wraps.
    always_comb begin
        prev_ext = {{(S+1){prev[A-1]}}, prev};
        diff_ext = {{(S+1){cur[A-1]}}, cur} - prev_ext;
        cnt_ext  = {{(A+1){1'b0}}, cnt};
        prod     = diff_ext * cnt_ext;
        step     = prod >>> S;
        interp   = A'(prev_ext + step);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state     <= IDLE;
            prev      <= '0;
            cur       <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            cnt       <= '0;
            audio     <= '0;
            underrun  <= 1'b0;
        end else begin
            audio    <= (state == IDLE) ? '0 : interp;
            underrun <= 1'b0;

            // A transfer only happens while the buffer is empty, so it never
            // collides with a consume of pend below.
            if (take) begin
                pend      <= in_sample;
                pend_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pend_full) begin
                        state     <= RUN;
                        prev      <= '0;
                        cur       <= pend;
                        pend_full <= 1'b0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        prev <= cur;
                        cnt  <= '0;
                        if (pend_full) begin
                            cur       <= pend;
                            pend_full <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            underrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    cnt <= '0;
                    if (pend_full) begin
                        state     <= RUN;
                        cur       <= pend;
                        pend_full <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_interpolator.sv
// Self-checking bench for audio_interpolator (A=8, S=2): directed ramps plus
// randomized traffic against a segment-based reference model.
module tb_audio_interpolator;

    localparam int A      = 8;
    localparam int S      = 2;
    localparam int PERIOD = 1 << S;
    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                enable    = 1'b0;
    logic                in_valid  = 1'b0;
    logic signed [A-1:0] in_sample = '0;
    logic                in_ready;
    logic signed [A-1:0] audio;
    logic                underrun;

    int checks   = 0;
    int failures = 0;

    int m_mode      = M_IDLE;
    int m_from      = 0;
    int m_to        = 0;
    int m_phase     = 0;
    int m_pend      = 0;
    bit m_has_pend  = 1'b0;
    int exp_audio   = 0;
    bit exp_underrun = 1'b0;
    bit m_took      = 1'b0;
    int dut_takes   = 0;

    int exp_q[$];

    always #5 clk = ~clk;

    audio_interpolator #(.A(A), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .audio     (audio),
        .underrun  (underrun)
    );

    function automatic int floorDiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: a segment runs from m_from to m_to over PERIOD phases; the
    // registered output shows the point on that line reached one clock earlier.
    task automatic modelStep(input bit r, input bit e, input bit v, input int s);
        bit took;
        if (!r || !e) begin
            m_mode = M_IDLE; m_from = 0; m_to = 0; m_phase = 0;
            m_pend = 0; m_has_pend = 1'b0;
            exp_audio = 0; exp_underrun = 1'b0;
            return;
        end
        took = v && !m_has_pend;
        exp_audio = (m_mode == M_IDLE) ? 0
                  : m_from + floorDiv((m_to - m_from) * m_phase, PERIOD);
        exp_underrun = 1'b0;
        if (m_mode == M_IDLE) begin
            if (m_has_pend) begin
                m_mode = M_RAMP; m_from = 0; m_to = m_pend;
                m_has_pend = 1'b0; m_phase = 0;
            end
        end else if (m_mode == M_RAMP) begin
            if (m_phase == PERIOD - 1) begin
                m_from = m_to; m_phase = 0;
                if (m_has_pend) begin
                    m_to = m_pend; m_has_pend = 1'b0;
                end else begin
                    m_mode = M_HOLD; exp_underrun = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end else if (m_has_pend) begin
            m_to = m_pend; m_has_pend = 1'b0; m_mode = M_RAMP; m_phase = 0;
        end
        if (took) begin
            m_pend = s; m_has_pend = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v, input int s);
        rst_n = r; enable = e; in_valid = v; in_sample = 8'(s);
        #1;
        checkOutput("in_ready", in_ready, (e && !m_has_pend) ? 1 : 0);
        if (in_valid && in_ready && r) dut_takes++;
        m_took = r && e && v && !m_has_pend;
        modelStep(r, e, v, s);
        @(negedge clk);
        checkOutput("audio", audio, exp_audio);
        checkOutput("underrun", underrun, exp_underrun);
    endtask

    initial begin
        int bp_val;
        int ext_val;
        int last_audio;
        int d;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 55);
            checkOutput("rst_audio", audio, 0);
            checkOutput("rst_ready_dis", in_ready, 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 55);
            checkOutput("rst_ready_en", in_ready, 1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            checkOutput("rst_no_accept", audio, 0);
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 8);
        exp_q = '{0, 0, 2, 4, 6, 8, 10, 12, 14, 16};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, (i < 2), 16);
            checkOutput("first_ramp", audio, exp_q[i]);
            if (i == 8) checkOutput("first_underrun", underrun, 1);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, -3);
        exp_q = '{0, 0, -1, -2, -3, -3};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            checkOutput("neg_floor", audio, exp_q[i]);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 20);
        exp_q = '{0, 0, 5, 10, 15, 20};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            checkOutput("ur_ramp", audio, exp_q[i]);
            if (i == 4) checkOutput("ur_pulse", underrun, 1);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            checkOutput("ur_hold", audio, 20);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, -20);
        exp_q = '{20, 20, 10, 0, -10, -20};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            checkOutput("ur_resume", audio, exp_q[i]);
        end

        // Source keeps in_valid high; a new value is offered only once the previous one is taken.
        bp_val = -60;
        for (int i = 0; i < 52; i++) begin
            if (i == 12) dut_takes = 0;
            applyStimulus(1'b1, 1'b1, 1'b1, bp_val);
            if (m_took) bp_val += 3;
        end
        checkOutput("bp_rate", dut_takes, 40 / PERIOD);

        ext_val = 127;
        last_audio = audio;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, ext_val);
            if (m_took) ext_val = (ext_val == 127) ? -128 : 127;
            checkOutput("ext_range", (audio >= -128 && audio <= 127), 1);
            d = int'(audio) - last_audio;
            if (d < 0) d = -d;
            if (i >= 12) checkOutput("ext_step", (d == 63 || d == 64), 1);
            last_audio = audio;
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 40);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 60);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("pre_disable", audio, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput("disable_flush", audio, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            checkOutput("pend_cleared", audio, 0);
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 9) < 3),
                          int'($urandom_range(0, 255)) - 128);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
